// File: rtl/spi_slave_if_if.sv
// ----------------------------------------------------------------------------
// spi_slave_if_if
// Bundle of the serial pins and the RAM-side handshake used by spi_slave_if.
//
// Signals:
//   ss_n     : slave select, active-low (from SPI master)
//   mosi     : serial data in, MSB first (from SPI master)
//   miso     : serial data out, MSB first (to SPI master)
//   tx_valid : one-cycle pulse from RAM, tx_data valid
//   tx_data  : read byte from RAM
//   rx_valid : one-cycle pulse to RAM, rx_data valid
//   rx_data  : captured frame, [9:8] command, [7:0] payload
//   cmd_err  : one-cycle pulse on command mismatch
//
// Modports:
//   slave  : the SPI slave front end (spi_slave_if)
//   master : the environment driving the SPI pins and modelling the RAM
// ----------------------------------------------------------------------------
interface spi_slave_if_if #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8
);
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  tx_valid;
    logic [DATA_BITS-1:0]  tx_data;
    logic                  rx_valid;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  cmd_err;

    modport slave (
        input  ss_n,
        input  mosi,
        input  tx_valid,
        input  tx_data,
        output miso,
        output rx_valid,
        output rx_data,
        output cmd_err
    );

    modport master (
        output ss_n,
        output mosi,
        output tx_valid,
        output tx_data,
        input  miso,
        input  rx_valid,
        input  rx_data,
        input  cmd_err
    );
endinterface

// File: rtl/spi_slave_if.sv
// ----------------------------------------------------------------------------
// spi_slave_if
// Serial-to-parallel front end for the SPI-controlled single-port RAM.
// Deserialises 10-bit command frames from MOSI into rx_data/rx_valid, and on a
// read-data frame captures the RAM's tx_data/tx_valid response and shifts the
// byte back out on MISO, MSB first. All logic runs on the SPI clock.
//
// Ports:
//   clk  : SPI serial clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : spi_slave_if_if.slave (ss_n, mosi, miso, tx_valid, tx_data,
//          rx_valid, rx_data, cmd_err)
//
// Configuration macro:
//   SPI_SLAVE_CMD_CHECK_EN : when defined, bit 8 of READ_ADD / READ_DATA frames
//   is checked at frame end; a mismatch pulses cmd_err instead of rx_valid.
//   When undefined, cmd_err is constant 0.
// ----------------------------------------------------------------------------
module spi_slave_if #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8
) (
    input logic           clk,
    input logic           rst,
    spi_slave_if_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0]  tx_sr_q, tx_sr_d;
    logic                  miso_q, miso_d;
    logic                  rd_addr_pending_q, rd_addr_pending_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  cmd_ok;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        rx_data_d         = rx_data_q;
        rx_valid_d        = 1'b0;
        tx_sr_d           = tx_sr_q;
        miso_d            = 1'b0;
        rd_addr_pending_d = rd_addr_pending_q;
        cmd_err_d         = 1'b0;
        cmd_ok            = 1'b1;

        if (bus.ss_n) begin
            // Deselect aborts whatever is in flight; the pending-read flag
            // survives so a READ_ADD/READ_DATA pair may span two selects.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = 4'd0;
                end

                CHK_CMD: begin
                    // Frame bits shift in from the LSB end, so after the last
                    // bit the first one has travelled up to rx_data[9].
                    rx_data_d = {{(FRAME_BITS-1){1'b0}}, bus.mosi};
                    cnt_d     = 4'd0;
                    if (!bus.mosi) begin
                        state_d = WRITE;
                    end else if (!rd_addr_pending_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    rx_data_d = {rx_data_q[FRAME_BITS-2:0], bus.mosi};
                    if (cnt_q == 4'(FRAME_BITS - 2)) begin
                        cnt_d = 4'd0;
`ifdef SPI_SLAVE_CMD_CHECK_EN
                        unique case (state_q)
                            READ_ADD:  cmd_ok = ~rx_data_d[FRAME_BITS-2];
                            READ_DATA: cmd_ok =  rx_data_d[FRAME_BITS-2];
                            default:   cmd_ok = 1'b1;
                        endcase
`else
                        cmd_ok = 1'b1;
`endif
                        if (cmd_ok) begin
                            rx_valid_d = 1'b1;
                            if (state_q == READ_DATA) begin
                                state_d = WAIT_TX;
                            end else begin
                                state_d = DONE;
                            end
                            if (state_q == READ_ADD) begin
                                rd_addr_pending_d = 1'b1;
                            end
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                WAIT_TX: begin
                    if (bus.tx_valid) begin
                        // MSB goes straight to miso; the rest queue in tx_sr.
                        miso_d  = bus.tx_data[DATA_BITS-1];
                        tx_sr_d = {bus.tx_data[DATA_BITS-2:0], 1'b0};
                        cnt_d   = 4'd0;
                        state_d = SEND;
                    end
                end

                SEND: begin
                    if (cnt_q == 4'(DATA_BITS - 1)) begin
                        cnt_d             = 4'd0;
                        rd_addr_pending_d = 1'b0;
                        state_d           = DONE;
                    end else begin
                        miso_d  = tx_sr_q[DATA_BITS-1];
                        tx_sr_d = {tx_sr_q[DATA_BITS-2:0], 1'b0};
                        cnt_d   = cnt_q + 4'd1;
                    end
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= 4'd0;
            rx_data_q         <= '0;
            rx_valid_q        <= 1'b0;
            tx_sr_q           <= '0;
            miso_q            <= 1'b0;
            rd_addr_pending_q <= 1'b0;
            cmd_err_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            rx_data_q         <= rx_data_d;
            rx_valid_q        <= rx_valid_d;
            tx_sr_q           <= tx_sr_d;
            miso_q            <= miso_d;
            rd_addr_pending_q <= rd_addr_pending_d;
            cmd_err_q         <= cmd_err_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.miso     = miso_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_if
// Self-checking bench for spi_slave_if. Frames are driven edge by edge; a
// frame-level model (edge numbering E0..E20, pending-read flag) sets the
// expected outputs after every rising edge and a single compare process checks
// them on every falling edge. Literal checks pin the model on known frames.
// ----------------------------------------------------------------------------
module tb_spi_slave_if;

    logic clk;
    logic rst;

    spi_slave_if_if bus ();

    spi_slave_if dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected values maintained by the model
    logic       exp_rv;
    logic       exp_miso;
    logic       exp_ce;
    logic [9:0] exp_rd;
    logic       exp_rst;
    logic       pend_m;
    logic       chk_on;

    // values observed by the frame task for literal checks
    logic       seen_rv;
    logic       seen_ce;
    logic [9:0] seen_rd;
    logic [7:0] miso_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rx_valid", 32'(bus.rx_valid), 32'(exp_rv));
            chk("miso", 32'(bus.miso), 32'(exp_miso));
            chk("cmd_err", 32'(bus.cmd_err), 32'(exp_ce));
            chk("rd_addr_pending", 32'(dut.rd_addr_pending_q), 32'(pend_m));
            if (exp_rv || exp_rst) begin
                chk("rx_data", 32'(bus.rx_data), 32'(exp_rd));
            end
        end
    end

    // one rising edge with the given inputs applied beforehand
    task automatic drive(input logic r, input logic ss, input logic m,
                         input logic tv, input logic [7:0] td);
        @(negedge clk);
        rst          = r;
        bus.ss_n     = ss;
        bus.mosi     = m;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_rv   = 1'b0;
        exp_miso = 1'b0;
        exp_ce   = 1'b0;
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // nbits < 10 aborts after that many frame bits; txdly < 0 means the RAM
    // never answers and reset is pulsed while waiting.
    task automatic frame(input logic [9:0] f, input int nbits,
                         input logic [7:0] ram, input int txdly);
        logic rd_add;
        logic rd_dat;
        logic ok;
        exp_rst = 1'b0;
        seen_rv = 1'b0;
        seen_ce = 1'b0;
        seen_rd = '0;
        drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);          // E0
        idle_exp();
        for (int i = 0; i < nbits; i++) begin            // E1..E10
            drive(1'b0, 1'b0, f[9-i], ($urandom_range(0, 3) == 0), 8'($urandom));
            idle_exp();
        end
        if (nbits == 10) begin
            rd_add = f[9] & ~pend_m;
            rd_dat = f[9] & pend_m;
            ok     = 1'b1;
`ifdef SPI_SLAVE_CMD_CHECK_EN
            if (rd_add && f[8])  ok = 1'b0;
            if (rd_dat && !f[8]) ok = 1'b0;
`endif
            exp_rv = ok;
            exp_ce = ~ok;
            exp_rd = f;
            if (ok && rd_add) pend_m = 1'b1;
            seen_rv = bus.rx_valid;
            seen_rd = bus.rx_data;
            seen_ce = bus.cmd_err;
            drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);      // E11
            idle_exp();
            if (ok && rd_dat) begin
                if (txdly < 0) begin
                    drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);
                    idle_exp();
                    drive(1'b1, 1'b0, rbit(), 1'b0, 8'h00);
                    idle_exp();
                    pend_m  = 1'b0;
                    exp_rd  = '0;
                    exp_rst = 1'b1;
                    drive(1'b0, 1'b1, rbit(), 1'b1, 8'hFF);
                    idle_exp();
                    drive(1'b0, 1'b1, rbit(), 1'b1, 8'h80);
                    idle_exp();
                    return;
                end
                for (int d = 0; d < txdly; d++) begin
                    drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);
                    idle_exp();
                end
                drive(1'b0, 1'b0, rbit(), 1'b1, ram);    // E12
                exp_miso     = ram[7];
                miso_seen[7] = bus.miso;
                for (int k = 6; k >= 0; k--) begin       // E13..E19
                    drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);
                    exp_miso     = ram[k];
                    miso_seen[k] = bus.miso;
                end
                drive(1'b0, 1'b0, rbit(), 1'b0, 8'h00);  // E20
                idle_exp();
                pend_m = 1'b0;
                drive(1'b0, 1'b0, rbit(), rbit(), 8'($urandom)); // DONE
                idle_exp();
            end
        end
        repeat ($urandom_range(1, 2)) begin
            drive(1'b0, 1'b1, rbit(), rbit(), 8'($urandom));
            idle_exp();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_on       = 1'b0;
        exp_rst      = 1'b0;
        pend_m       = 1'b0;
        miso_seen    = '0;
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        idle_exp();
        exp_rd  = '0;
        exp_rst = 1'b1;
        chk_on  = 1'b1;
        chk("reset_rx_data", 32'(bus.rx_data), 32'h0);
        chk("reset_pend", 32'(dut.rd_addr_pending_q), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // plain write frame
        frame(10'h005, 10, 8'h00, 0);
        chk("lit_wr_valid", 32'(seen_rv), 32'h1);
        chk("lit_wr_data", 32'(seen_rd), 32'h005);

        frame(10'h1A5, 10, 8'h00, 0);
        chk("lit_wr2_data", 32'(seen_rd), 32'h1A5);
        chk("lit_wr2_pend", 32'(dut.rd_addr_pending_q), 32'h0);

        // read address then read data with RAM byte A5
        frame(10'h205, 10, 8'h00, 0);
        chk("lit_rdadd_pend", 32'(dut.rd_addr_pending_q), 32'h1);
        frame({2'b11, 8'($urandom)}, 10, 8'hA5, 0);
        chk("lit_rddat_cmd", 32'(seen_rd[9:8]), 32'h3);
        chk("lit_rddat_miso", 32'(miso_seen), 32'hA5);
        chk("lit_rddat_pend", 32'(dut.rd_addr_pending_q), 32'h0);

        // aborted write then a full one
        frame(10'h0C3, 5, 8'h00, 0);
        chk("lit_abort_pend", 32'(dut.rd_addr_pending_q), 32'h0);
        frame(10'h0F0, 10, 8'h00, 0);
        chk("lit_after_abort", 32'(seen_rd), 32'h0F0);

        // reset while waiting for the RAM
        frame(10'h200, 10, 8'h00, 0);
        frame(10'h3AA, 10, 8'h00, -1);
        chk("lit_rst_pend", 32'(dut.rd_addr_pending_q), 32'h0);
        chk("lit_rst_miso", 32'(bus.miso), 32'h0);

        // READ_ADD frame with bit 8 set
        frame(10'h301, 10, 8'h00, 0);
`ifdef SPI_SLAVE_CMD_CHECK_EN
        chk("lit_cmd_err", 32'(seen_ce), 32'h1);
        chk("lit_cmd_norv", 32'(seen_rv), 32'h0);
        chk("lit_cmd_pend", 32'(dut.rd_addr_pending_q), 32'h0);
`else
        chk("lit_cmd_rv", 32'(seen_rv), 32'h1);
        chk("lit_cmd_data", 32'(seen_rd), 32'h301);
        chk("lit_cmd_pend", 32'(dut.rd_addr_pending_q), 32'h1);
`endif

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            frame(10'($urandom),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10,
                  8'($urandom), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
